// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences fetch/decode/exec/mem/wb around a shared memory port.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_code,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Last waiting cycle allowed before declaring a bus error.
    localparam int              TMO_LIM_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_LIM_I[TMO_W-1:0];
    localparam bit              TMO_EN    = (MEM_TIMEOUT != 0);

    state_t           r_state;
    logic [TMO_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_bus_err;

    logic [6:0]       w_opc;
    logic             w_load;
    logic             w_opimm;
    logic             w_op;
    logic             w_lui;
    logic             w_store;
    logic             w_branch;
    logic             w_jal;
    logic             w_legal;
    logic             w_tmo;
    logic [TMO_W-1:0] w_cnt_inc;
    logic             w_unused;

    assign w_opc    = inst_code[6:0];
    assign w_load   = (w_opc == OPC_LOAD);
    assign w_opimm  = (w_opc == OPC_OPIMM);
    assign w_op     = (w_opc == OPC_OP);
    assign w_lui    = (w_opc == OPC_LUI);
    assign w_store  = (w_opc == OPC_STORE);
    assign w_branch = (w_opc == OPC_BRANCH);
    assign w_jal    = (w_opc == OPC_JAL);
    assign w_legal  = w_load | w_opimm | w_op | w_lui |
                      w_store | w_branch | w_jal;
    assign w_unused = ^inst_code[31:7];

    // Saturating wait counter; the timeout fires on the last allowed wait.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_tmo     = TMO_EN && (r_cnt == TMO_LIM);

    // State sequencing, wait counting and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_tmo) begin
                        r_bus_err <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (w_load || w_store) begin
                        r_state <= S_MEM;
                        r_cnt   <= '0;
                    end else if (w_op || w_opimm || w_lui) begin
                        r_state <= S_WB;
                    end else if (w_branch || w_jal) begin
                        r_state <= S_FETCH;
                        r_cnt   <= '0;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_load) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                            r_cnt   <= '0;
                        end
                    end else if (w_tmo) begin
                        r_bus_err <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_cnt   <= '0;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_TRAP;
                end
            endcase
        end
    end

    // Per-state datapath controls; forced low while reset is asserted.
    always_comb begin
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_imm  = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                S_EXEC: begin
                    alu_src_imm = w_load | w_store | w_opimm;
                    if (w_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken;
                        retire = 1'b1;
                    end else if (w_jal) begin
                        reg_we = 1'b1;
                        wb_sel = 2'd2;
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    alu_src_imm  = 1'b1;
                    mem_we       = w_store;
                    if (mem_ready && w_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    if (w_load) begin
                        wb_sel = 2'd1;
                    end else if (w_lui) begin
                        wb_sel = 2'd3;
                    end else begin
                        wb_sel = 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal = r_illegal;
    assign bus_err = r_bus_err;
    assign state_o = r_state;

endmodule
